// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - MIPS ALU issue/result controller: decode into a registered issue stage, capture ALU result into a registered result stage.
// Optional overflow trapping for ADD/ADDI/SUB is enabled by defining ALU_OVF_TRAP_EN.
module alu_issue_ctrl #(
  parameter int RESET_PC_UNUSED = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_aluc,
  input  logic [31:0] alu_y,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic        exc_ovf,
  output logic        exc_ill
);

  if (RESET_PC_UNUSED != 0) begin : g_reserved
  end

  logic [5:0]  op, funct;
  logic [4:0]  f_rs, f_rt, f_rd, shamt;
  logic [15:0] imm;
  logic [31:0] sext_imm, zext_imm;

  assign op       = instr[31:26];
  assign f_rs     = instr[25:21];
  assign f_rt     = instr[20:16];
  assign f_rd     = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm      = instr[15:0];
  assign sext_imm = {{16{imm[15]}}, imm};
  assign zext_imm = {16'b0, imm};

  logic [3:0]  d_aluc;
  logic [31:0] d_a, d_b, d_tgt;
  logic [4:0]  d_rd;
  logic        d_beq, d_bne, d_ill, d_we, d_ovf;

  always_comb begin
    d_aluc = 4'b0000;
    d_a    = 32'b0;
    d_b    = 32'b0;
    d_rd   = 5'b0;
    d_beq  = 1'b0;
    d_bne  = 1'b0;
    d_ill  = 1'b0;
    d_ovf  = 1'b0;
    case (op)
      6'h00: begin
        d_rd = f_rd;
        d_a  = rs_data;
        d_b  = rt_data;
        case (funct)
          6'h20: begin d_aluc = 4'b0000; d_ovf = 1'b1; end
          6'h21: d_aluc = 4'b0001;
          6'h22: begin d_aluc = 4'b0010; d_ovf = 1'b1; end
          6'h23: d_aluc = 4'b0011;
          6'h24: d_aluc = 4'b0100;
          6'h25: d_aluc = 4'b0101;
          6'h26: d_aluc = 4'b0110;
          6'h27: d_aluc = 4'b0111;
          6'h2A: d_aluc = 4'b1000;
          6'h2B: d_aluc = 4'b1001;
          6'h00: begin d_aluc = 4'b1010; d_a = {27'b0, shamt}; end
          6'h02: begin d_aluc = 4'b1011; d_a = {27'b0, shamt}; end
          6'h03: begin d_aluc = 4'b1100; d_a = {27'b0, shamt}; end
          6'h04: begin d_aluc = 4'b1010; d_a = {27'b0, rs_data[4:0]}; end
          6'h06: begin d_aluc = 4'b1011; d_a = {27'b0, rs_data[4:0]}; end
          6'h07: begin d_aluc = 4'b1100; d_a = {27'b0, rs_data[4:0]}; end
          default: begin
            d_ill = 1'b1;
            d_a   = 32'b0;
            d_b   = 32'b0;
          end
        endcase
      end
      6'h04, 6'h05: begin
        d_aluc = 4'b0011;
        d_a    = rs_data;
        d_b    = rt_data;
        d_beq  = (op == 6'h04);
        d_bne  = (op == 6'h05);
      end
      6'h08: begin d_aluc = 4'b0000; d_rd = f_rt; d_a = rs_data; d_b = sext_imm; d_ovf = 1'b1; end
      6'h09: begin d_aluc = 4'b0001; d_rd = f_rt; d_a = rs_data; d_b = sext_imm; end
      6'h0A: begin d_aluc = 4'b1000; d_rd = f_rt; d_a = rs_data; d_b = sext_imm; end
      6'h0B: begin d_aluc = 4'b1001; d_rd = f_rt; d_a = rs_data; d_b = sext_imm; end
      6'h0C: begin d_aluc = 4'b0100; d_rd = f_rt; d_a = rs_data; d_b = zext_imm; end
      6'h0D: begin d_aluc = 4'b0101; d_rd = f_rt; d_a = rs_data; d_b = zext_imm; end
      6'h0E: begin d_aluc = 4'b0110; d_rd = f_rt; d_a = rs_data; d_b = zext_imm; end
      6'h0F: begin d_aluc = 4'b1101; d_rd = f_rt; d_a = rs_data; d_b = zext_imm; end
      default: d_ill = 1'b1;
    endcase
  end

  // Branches and illegal ops never write; writes to $0 are suppressed too.
  assign d_we  = !d_ill && !d_beq && !d_bne && (d_rd != 5'd0);
  assign d_tgt = pc + 32'd4 + {sext_imm[29:0], 2'b00};

  logic        s1_valid, s2_valid, s2_free, load, adv;
  logic [4:0]  s1_rd;
  logic        s1_we, s1_beq, s1_bne, s1_ill;
  logic [31:0] s1_tgt;
  logic        trap;

  assign s2_free   = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_free;
  assign load      = in_valid && in_ready;
  assign adv       = s1_valid && s2_free;
  assign out_valid = s2_valid;

`ifdef ALU_OVF_TRAP_EN
  logic s1_ovf;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    s1_ovf <= 1'b0;
    else if (load) s1_ovf <= d_ovf;
  end
  assign trap = s1_ovf && alu_overflow;
`else
  logic unused_ovf;
  assign unused_ovf = alu_overflow ^ d_ovf;
  assign trap       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      alu_a    <= 32'b0;
      alu_b    <= 32'b0;
      alu_aluc <= 4'b0;
      s1_rd    <= 5'b0;
      s1_we    <= 1'b0;
      s1_beq   <= 1'b0;
      s1_bne   <= 1'b0;
      s1_ill   <= 1'b0;
      s1_tgt   <= 32'b0;
    end else if (load) begin
      s1_valid <= 1'b1;
      alu_a    <= d_a;
      alu_b    <= d_b;
      alu_aluc <= d_aluc;
      s1_rd    <= d_rd;
      s1_we    <= d_we;
      s1_beq   <= d_beq;
      s1_bne   <= d_bne;
      s1_ill   <= d_ill;
      s1_tgt   <= d_tgt;
    end else if (adv) begin
      // Empty issue stage presents zero operands to the ALU.
      s1_valid <= 1'b0;
      alu_a    <= 32'b0;
      alu_b    <= 32'b0;
      alu_aluc <= 4'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_rd     <= 5'b0;
      wb_data   <= 32'b0;
      br_taken  <= 1'b0;
      br_target <= 32'b0;
      exc_ovf   <= 1'b0;
      exc_ill   <= 1'b0;
    end else if (adv) begin
      s2_valid  <= 1'b1;
      wb_we     <= s1_we && !trap;
      wb_rd     <= s1_rd;
      wb_data   <= alu_y;
      br_taken  <= (s1_beq && alu_zero) || (s1_bne && !alu_zero);
      br_target <= s1_tgt;
      exc_ovf   <= trap;
      exc_ill   <= s1_ill;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl with a behavioural ALU and result scoreboard.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, pc, rs_data, rt_data, alu_a, alu_b, alu_y;
  logic [3:0]  alu_aluc;
  logic        alu_zero, alu_overflow;
  logic        wb_we, br_taken, exc_ovf, exc_ill;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, br_target;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs_data(rs_data), .rt_data(rt_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc),
    .alu_y(alu_y), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .br_taken(br_taken), .br_target(br_target),
    .exc_ovf(exc_ovf), .exc_ill(exc_ill)
  );

  always_comb begin
    alu_y        = 32'b0;
    alu_overflow = 1'b0;
    case (alu_aluc)
      4'd0, 4'd1: begin
        alu_y = alu_a + alu_b;
        alu_overflow = (alu_a[31] == alu_b[31]) && (alu_y[31] != alu_a[31]);
      end
      4'd2, 4'd3: begin
        alu_y = alu_a - alu_b;
        alu_overflow = (alu_a[31] != alu_b[31]) && (alu_y[31] != alu_a[31]);
      end
      4'd4:  alu_y = alu_a & alu_b;
      4'd5:  alu_y = alu_a | alu_b;
      4'd6:  alu_y = alu_a ^ alu_b;
      4'd7:  alu_y = ~(alu_a | alu_b);
      4'd8:  alu_y = {31'b0, $signed(alu_a) < $signed(alu_b)};
      4'd9:  alu_y = {31'b0, alu_a < alu_b};
      4'd10: alu_y = alu_b << alu_a[4:0];
      4'd11: alu_y = alu_b >> alu_a[4:0];
      4'd12: alu_y = $unsigned($signed(alu_b) >>> alu_a[4:0]);
      4'd13: alu_y = alu_b << 16;
      default: alu_y = 32'b0;
    endcase
  end
  assign alu_zero = (alu_y == 32'b0);

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        isbr;
    logic        br;
    logic [31:0] tgt;
    logic        ovf;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic we, input logic [4:0] rd, input logic [31:0] data,
                              input logic isbr, input logic br, input logic [31:0] tgt,
                              input logic ovf, input logic ill);
    exp_t e;
    e = '{we: we, rd: rd, data: data, isbr: isbr, br: br, tgt: tgt, ovf: ovf, ill: ill};
    return e;
  endfunction

  function automatic logic [31:0] r_op(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] opc, input logic [4:0] rs, rt, input logic [15:0] im);
    return {opc, rs, rt, im};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_unexpected_output observed=%h expected=none", wb_data);
      end else begin
        e = sb.pop_front();
        chk("res_wb_we", {31'b0, wb_we}, {31'b0, e.we});
        if (e.we) chk("res_wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
        chk("res_wb_data", wb_data, e.data);
        chk("res_br_taken", {31'b0, br_taken}, {31'b0, e.br});
        if (e.isbr) chk("res_br_target", br_target, e.tgt);
        chk("res_exc_ovf", {31'b0, exc_ovf}, {31'b0, e.ovf});
        chk("res_exc_ill", {31'b0, exc_ill}, {31'b0, e.ill});
      end
    end
  end

  task automatic issue(input logic [31:0] ins, input logic [31:0] p, input logic [31:0] rs,
                       input logic [31:0] rt, input exp_t e);
    int n = 0;
    instr = ins; pc = p; rs_data = rs; rt_data = rt; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        sb.push_back(e);
        break;
      end
      n++;
      if (n > 50) begin
        checks++; errors++;
        $error("FAIL issue_timeout observed=in_ready_low expected=accept");
        break;
      end
    end
  endtask

  task automatic idle();
    in_valid = 1'b0; instr = 32'b0; pc = 32'b0; rs_data = 32'b0; rt_data = 32'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 || out_valid) begin
      @(negedge clk);
      n++;
      if (n > 30) begin
        checks++; errors++;
        $error("FAIL drain_timeout observed=%0d expected=0", sb.size());
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held_b;
    rst_n = 1'b0; out_ready = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_alu_aluc", {28'b0, alu_aluc}, 32'd0);
    chk("rst_wb_we", {31'b0, wb_we}, 32'd0);
    @(posedge clk); #1;

    // ADDU $3,$1,$2 -> 5+7
    issue(r_op(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 32'h0, 32'd5, 32'd7,
          mk(1'b1, 5'd3, 32'd12, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
    idle();
    @(negedge clk);
    chk("addu_aluc", {28'b0, alu_aluc}, 32'h1);
    chk("addu_a", alu_a, 32'd5);
    chk("addu_b", alu_b, 32'd7);
    @(posedge clk); #1;
    @(negedge clk);
    chk("addu_out_valid", {31'b0, out_valid}, 32'd1);
    chk("addu_s1_empty_a", alu_a, 32'd0);
    drain();

    // SRA $4,$2,4
    issue(r_op(5'd0, 5'd2, 5'd4, 5'd4, 6'h03), 32'h0, 32'h0, 32'hF000_0000,
          mk(1'b1, 5'd4, 32'hFF00_0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
    idle();
    @(negedge clk);
    chk("sra_a", alu_a, 32'd4);
    chk("sra_aluc", {28'b0, alu_aluc}, 32'hC);
    drain();

    // SLLV $5,$2,$1 with rs=0x23 -> shift by 3
    issue(r_op(5'd1, 5'd2, 5'd5, 5'd0, 6'h04), 32'h0, 32'h23, 32'h1,
          mk(1'b1, 5'd5, 32'h8, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
    idle();
    @(negedge clk);
    chk("sllv_a", alu_a, 32'd3);
    drain();

    // BEQ at 0x100 with imm=-1: target 0x100
    issue(i_op(6'h04, 5'd1, 5'd2, 16'hFFFF), 32'h100, 32'd9, 32'd9,
          mk(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0));
    issue(i_op(6'h04, 5'd1, 5'd2, 16'hFFFF), 32'h100, 32'd9, 32'd8,
          mk(1'b0, 5'd0, 32'd1, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0));
    issue(i_op(6'h05, 5'd1, 5'd2, 16'h0010), 32'h200, 32'd9, 32'd8,
          mk(1'b0, 5'd0, 32'd1, 1'b1, 1'b1, 32'h244, 1'b0, 1'b0));
    idle();
    drain();

    // ADD overflow
`ifdef ALU_OVF_TRAP_EN
    issue(r_op(5'd1, 5'd2, 5'd6, 5'd0, 6'h20), 32'h0, 32'h7FFF_FFFF, 32'd1,
          mk(1'b0, 5'd6, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0));
`else
    issue(r_op(5'd1, 5'd2, 5'd6, 5'd0, 6'h20), 32'h0, 32'h7FFF_FFFF, 32'd1,
          mk(1'b1, 5'd6, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
`endif
    // ADDU to $0 never writes back
    issue(r_op(5'd1, 5'd2, 5'd0, 5'd0, 6'h21), 32'h0, 32'd1, 32'd2,
          mk(1'b0, 5'd0, 32'd3, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
    // LUI $7,0x1234
    issue(i_op(6'h0F, 5'd0, 5'd7, 16'h1234), 32'h0, 32'h0, 32'h0,
          mk(1'b1, 5'd7, 32'h1234_0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
    // illegal opcode 0x3F
    issue(i_op(6'h3F, 5'd1, 5'd2, 16'h1234), 32'h0, 32'h55, 32'h66,
          mk(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1));
    idle();
    @(negedge clk);
    chk("ill_aluc", {28'b0, alu_aluc}, 32'd0);
    chk("ill_a", alu_a, 32'd0);
    drain();

    // ORI stream with a 3-cycle output stall
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          issue(i_op(6'h0D, 5'd1, 5'(8 + i), 16'(16'h0010 * i + 1)), 32'h0, 32'hA000_0000, 32'h0,
                mk(1'b1, 5'(8 + i), 32'hA000_0000 | 32'(16'h0010 * i + 1), 1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
        end
        idle();
      end
      begin
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
        chk("stall_accepts", 32'(sb.size()), 32'd2);
        held_b = alu_b;
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_alu_b_held", alu_b, held_b);
        chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // asynchronous reset with both stages full
    out_ready = 1'b0;
    issue(i_op(6'h0D, 5'd1, 5'd9, 16'h00F0), 32'h0, 32'h1, 32'h0,
          mk(1'b1, 5'd9, 32'hF1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
    issue(i_op(6'h0D, 5'd1, 5'd10, 16'h0F00), 32'h0, 32'h2, 32'h0,
          mk(1'b1, 5'd10, 32'hF02, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
    idle();
    @(negedge clk);
    chk("full_out_valid", {31'b0, out_valid}, 32'd1);
    chk("full_aluc", {28'b0, alu_aluc}, 32'h5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_aluc", {28'b0, alu_aluc}, 32'd0);
    chk("arst_alu_b", alu_b, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;

    issue(i_op(6'h0A, 5'd1, 5'd11, 16'hFFFF), 32'h0, 32'hFFFF_FFFE, 32'h0,
          mk(1'b1, 5'd11, 32'd1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
    idle();
    drain();
    chk("sb_empty_end", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
